// File: rtl/daq_sequencer_pkg.sv
// Shared types and constants for the acquisition sequencer.
package daq_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_POWER_UP,
        ST_RESET_CHIP,
        ST_ARM,
        ST_ACQUIRE,
        ST_HOLD,
        ST_READOUT,
        ST_ONCE_END,
        ST_DONE
    } daq_state_t;

    // Acquisition modes selected by DaqMode; code 3 behaves as DAQ_AUTO.
    localparam logic [1:0] DAQ_AUTO  = 2'd0;
    localparam logic [1:0] DAQ_EXT   = 2'd1;
    localparam logic [1:0] DAQ_BURST = 2'd2;

endpackage

// File: rtl/daq_sequencer_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
module sync_edge
    import daq_sequencer_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Synchronise, keep one cycle of history, and flag a 0->1 transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            rise    <= sync_p1 & ~sync_p2;
        end
    end

endmodule

// File: rtl/daq_sequencer.sv
// Acquire -> hold -> readout sequencer for a multi-ASIC readout chain.
// Every output is a register loaded from the next-state decode, so outputs
// change on the same edge as the state they belong to.
module daq_sequencer
    import daq_sequencer_pkg::*;
#(
    parameter int NUM_ASIC  = 4,
    parameter int TIME_W    = 16,
    parameter int RESET_LEN = 8
) (
    input  logic                Clk,
    input  logic                reset_n,
    input  logic [1:0]          DaqMode,
    input  logic                UsbAcqStart,
    input  logic [15:0]         AcqCycles,
    input  logic                PowerPulseEn,
    input  logic [TIME_W-1:0]   AcquisitionTime,
    input  logic [TIME_W-1:0]   EndHoldTime,
    input  logic [TIME_W-1:0]   PowerOnDelay,
    input  logic [NUM_ASIC-1:0] CHIPSATB,
    input  logic                ExternalTrigger,
    input  logic                EndReadout,
    input  logic                UsbFifoEmpty,
    input  logic                DataTransmitDone,
    output logic                START_ACQ,
    output logic                RESET_B,
    output logic                PWR_ON_A,
    output logic                PWR_ON_D,
    output logic                PWR_ON_ADC,
    output logic                PWR_ON_DAC,
    output logic                StartReadout,
    output logic                OnceEnd,
    output logic                UsbStartStop,
    output logic                AllDone,
    output logic [15:0]         CycleCount,
    output logic [NUM_ASIC-1:0] ChipFullMask
);

    // A programmed duration of zero still occupies one cycle.
    function automatic logic [TIME_W-1:0] at_least_one(input logic [TIME_W-1:0] d);
        return (d == '0) ? TIME_W'(1) : d;
    endfunction

    // Completed-cycle counter sticks at its maximum instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    daq_state_t          state, state_nxt;
    logic [TIME_W-1:0]   timer, timer_nxt;
    logic                timer_last;
    logic                stop_req, stop_nxt;
    logic [NUM_ASIC-1:0] chip_sync_p0, chip_sync_p1;
    logic [NUM_ASIC-1:0] chip_full;
    logic                any_full;
    logic                trig_rise;
    logic                arm_go;
    logic                burst_last;
    logic [15:0]         count_nxt;
    logic [NUM_ASIC-1:0] mask_nxt;
    logic                usb_ss_nxt;
    logic                rails_on, analog_on;

    // Chip-full flags are active-low and asynchronous; idle level is "not full".
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            chip_sync_p0 <= '1;
            chip_sync_p1 <= '1;
        end else begin
            chip_sync_p0 <= CHIPSATB;
            chip_sync_p1 <= chip_sync_p0;
        end
    end

    assign chip_full  = ~chip_sync_p1;
    assign any_full   = |chip_full;
    assign timer_last = (timer <= TIME_W'(1));

    sync_edge u_trig_sync (
        .clk   (Clk),
        .rst_n (reset_n),
        .din   (ExternalTrigger),
        .rise  (trig_rise)
    );

    // Next-state, duration timer, counters and registered-output decode.
    always_comb begin
        state_nxt  = state;
        timer_nxt  = (timer != '0) ? timer - TIME_W'(1) : timer;
        count_nxt  = CycleCount;
        mask_nxt   = ChipFullMask;
        usb_ss_nxt = UsbStartStop;
        stop_nxt   = stop_req | ~UsbAcqStart;
        burst_last = (DaqMode == DAQ_BURST) && (AcqCycles != 16'd0) &&
                     (({1'b0, CycleCount} + 17'd1) == {1'b0, AcqCycles});

        case (DaqMode)
            DAQ_EXT:             arm_go = trig_rise;
            DAQ_AUTO, DAQ_BURST: arm_go = 1'b1;
            default:             arm_go = 1'b1;
        endcase

        unique case (state)
            ST_IDLE: begin
                stop_nxt = 1'b0;
                if (UsbAcqStart) begin
                    count_nxt  = '0;
                    usb_ss_nxt = 1'b1;
                    state_nxt  = ST_POWER_UP;
                    timer_nxt  = at_least_one(PowerOnDelay);
                end
            end
            ST_POWER_UP: begin
                if (timer_last) begin
                    // Chips are reset only before the first cycle of a run.
                    if (CycleCount == 16'd0) begin
                        state_nxt = ST_RESET_CHIP;
                        timer_nxt = TIME_W'(RESET_LEN);
                    end else begin
                        state_nxt = ST_ARM;
                    end
                end
            end
            ST_RESET_CHIP: begin
                if (timer_last) state_nxt = ST_ARM;
            end
            ST_ARM: begin
                if (!UsbAcqStart || stop_req) begin
                    state_nxt = ST_DONE;
                end else if (arm_go) begin
                    state_nxt = ST_ACQUIRE;
                    timer_nxt = at_least_one(AcquisitionTime);
                end
            end
            ST_ACQUIRE: begin
                if (any_full || timer_last) begin
                    state_nxt = ST_HOLD;
                    mask_nxt  = chip_full;
                    timer_nxt = at_least_one(EndHoldTime);
                end
            end
            ST_HOLD: begin
                if (timer_last) state_nxt = ST_READOUT;
            end
            ST_READOUT: begin
                if (EndReadout) state_nxt = ST_ONCE_END;
            end
            ST_ONCE_END: begin
                count_nxt = sat_inc(CycleCount);
                if (stop_req || !UsbAcqStart || burst_last) begin
                    state_nxt = ST_DONE;
                end else if (PowerPulseEn) begin
                    state_nxt = ST_POWER_UP;
                    timer_nxt = at_least_one(PowerOnDelay);
                end else begin
                    state_nxt = ST_ARM;
                end
            end
            ST_DONE: begin
                // Drop the stream flag once the FIFO drains, then wait for the host.
                if (UsbStartStop) begin
                    if (UsbFifoEmpty) usb_ss_nxt = 1'b0;
                end else if (DataTransmitDone) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        rails_on  = !(state_nxt inside {ST_IDLE, ST_DONE});
        analog_on = rails_on && !(PowerPulseEn && (state_nxt inside {ST_READOUT, ST_ONCE_END}));
    end

    // State, timer and all registered outputs.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            timer        <= '0;
            stop_req     <= 1'b0;
            START_ACQ    <= 1'b0;
            RESET_B      <= 1'b1;
            PWR_ON_A     <= 1'b0;
            PWR_ON_D     <= 1'b0;
            PWR_ON_ADC   <= 1'b0;
            PWR_ON_DAC   <= 1'b0;
            StartReadout <= 1'b0;
            OnceEnd      <= 1'b0;
            UsbStartStop <= 1'b0;
            AllDone      <= 1'b0;
            CycleCount   <= '0;
            ChipFullMask <= '0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            stop_req     <= stop_nxt;
            START_ACQ    <= (state_nxt == ST_ACQUIRE);
            RESET_B      <= (state_nxt != ST_RESET_CHIP);
            PWR_ON_A     <= analog_on;
            PWR_ON_D     <= rails_on;
            PWR_ON_ADC   <= analog_on;
            PWR_ON_DAC   <= analog_on;
            StartReadout <= (state_nxt == ST_READOUT) && (state != ST_READOUT);
            OnceEnd      <= (state_nxt == ST_ONCE_END);
            UsbStartStop <= usb_ss_nxt;
            AllDone      <= (state_nxt == ST_DONE);
            CycleCount   <= count_nxt;
            ChipFullMask <= mask_nxt;
        end
    end

endmodule
